// File: rtl/alu_result_tx_ctrl.sv
// Consumer end of the ALU result interface: captures result words and serialises them
// byte by byte into the UART TX FIFO write port, honouring FIFO back-pressure.
module alu_result_tx_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter bit          LSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  async_rst,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic                  OUT_Valid,
    input  logic                  FIFO_Full,
    output logic [BYTE_WIDTH-1:0] WR_DATA,
    output logic                  WR_INC,
    output logic                  RES_Ready,
    output logic                  Overrun,
    input  logic                  Overrun_Clr
);

    localparam int unsigned      NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned      CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_BYTES - 1);

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  overrun_q, overrun_d;

    logic                  in_send;
    logic                  last_write;
    logic                  accept;
    logic                  drop;
    logic [BYTE_WIDTH-1:0] send_byte;
    logic [DATA_WIDTH-1:0] hold_shifted;

    always_comb begin
        in_send = (state_q == StSend);

        // The byte on the wire always sits at the sent end; shifting moves the next one there.
        if (LSB_FIRST) begin
            send_byte    = hold_q[BYTE_WIDTH-1:0];
            hold_shifted = hold_q >> BYTE_WIDTH;
        end else begin
            send_byte    = hold_q[DATA_WIDTH-1 -: BYTE_WIDTH];
            hold_shifted = hold_q << BYTE_WIDTH;
        end

        WR_INC     = in_send & ~FIFO_Full;
        WR_DATA    = in_send ? send_byte : '0;
        last_write = WR_INC & (cnt_q == LAST_CNT);
        RES_Ready  = ~in_send | last_write;

        accept = OUT_Valid & RES_Ready;
        drop   = OUT_Valid & ~RES_Ready;

        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;

        if (accept) begin
            state_d = StSend;
            hold_d  = ALU_OUT;
            cnt_d   = '0;
        end else if (last_write) begin
            state_d = StIdle;
            hold_d  = hold_shifted;
            cnt_d   = '0;
        end else if (WR_INC) begin
            hold_d = hold_shifted;
            cnt_d  = cnt_q + CNT_W'(1);
        end

        // A drop in the same cycle as a clear keeps the flag set.
        overrun_d = drop | (overrun_q & ~Overrun_Clr);
    end

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    assign Overrun = overrun_q;

endmodule

// File: tb/tb_alu_result_tx_ctrl.sv
// Directed bench for alu_result_tx_ctrl: an LSB-first and an MSB-first instance share
// one stimulus stream; each cycle's outputs are compared against hand-computed values.
module tb_alu_result_tx_ctrl;

    logic        clk = 1'b0;
    logic        async_rst = 1'b0;
    logic [15:0] alu_out = '0;
    logic        out_valid = 1'b0;
    logic        fifo_full = 1'b0;
    logic        overrun_clr = 1'b0;

    logic [7:0]  wr_data_l, wr_data_m;
    logic        wr_inc_l, wr_inc_m;
    logic        ready_l, ready_m;
    logic        ovr_l, ovr_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_result_tx_ctrl #(
        .DATA_WIDTH(16),
        .BYTE_WIDTH(8),
        .LSB_FIRST (1'b1)
    ) u_lsb (
        .clk        (clk),
        .async_rst  (async_rst),
        .ALU_OUT    (alu_out),
        .OUT_Valid  (out_valid),
        .FIFO_Full  (fifo_full),
        .WR_DATA    (wr_data_l),
        .WR_INC     (wr_inc_l),
        .RES_Ready  (ready_l),
        .Overrun    (ovr_l),
        .Overrun_Clr(overrun_clr)
    );

    alu_result_tx_ctrl #(
        .DATA_WIDTH(16),
        .BYTE_WIDTH(8),
        .LSB_FIRST (1'b0)
    ) u_msb (
        .clk        (clk),
        .async_rst  (async_rst),
        .ALU_OUT    (alu_out),
        .OUT_Valid  (out_valid),
        .FIFO_Full  (fifo_full),
        .WR_DATA    (wr_data_m),
        .WR_INC     (wr_inc_m),
        .RES_Ready  (ready_m),
        .Overrun    (ovr_m),
        .Overrun_Clr(overrun_clr)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 3 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        // Reset, idle
        #2;
        check("rst_wr_inc", 16'(wr_inc_l), 16'h0);
        check("rst_ready", 16'(ready_l), 16'h1);
        check("rst_overrun", 16'(ovr_l), 16'h0);
        check("rst_wr_data", 16'(wr_data_l), 16'h00);
        @(negedge clk);
        async_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); settle();
            check("idle_no_write", 16'(wr_inc_l), 16'h0);
        end

        // Single word, LSB first
        next_cycle(); alu_out = 16'hA55A; out_valid = 1'b1; settle();
        check("sw_c0_ready", 16'(ready_l), 16'h1);
        check("sw_c0_wr_inc", 16'(wr_inc_l), 16'h0);
        next_cycle(); out_valid = 1'b0; settle();
        check("sw_c1_wr_inc", 16'(wr_inc_l), 16'h1);
        check("sw_c1_data", 16'(wr_data_l), 16'h5A);
        check("sw_c1_ready", 16'(ready_l), 16'h0);
        next_cycle(); settle();
        check("sw_c2_wr_inc", 16'(wr_inc_l), 16'h1);
        check("sw_c2_data", 16'(wr_data_l), 16'hA5);
        check("sw_c2_ready", 16'(ready_l), 16'h1);
        next_cycle(); settle();
        check("sw_c3_wr_inc", 16'(wr_inc_l), 16'h0);
        check("sw_c3_ready", 16'(ready_l), 16'h1);

        // Back-pressure
        next_cycle(); alu_out = 16'h0001; out_valid = 1'b1; settle();
        for (int c = 1; c <= 3; c++) begin
            next_cycle(); out_valid = 1'b0; fifo_full = 1'b1; settle();
            check("bp_full_wr_inc", 16'(wr_inc_l), 16'h0);
            check("bp_full_data", 16'(wr_data_l), 16'h01);
            check("bp_full_ready", 16'(ready_l), 16'h0);
        end
        next_cycle(); fifo_full = 1'b0; settle();
        check("bp_c4_wr_inc", 16'(wr_inc_l), 16'h1);
        check("bp_c4_data", 16'(wr_data_l), 16'h01);
        next_cycle(); settle();
        check("bp_c5_wr_inc", 16'(wr_inc_l), 16'h1);
        check("bp_c5_data", 16'(wr_data_l), 16'h00);
        check("bp_c5_ready", 16'(ready_l), 16'h1);
        next_cycle(); settle();
        check("bp_c6_wr_inc", 16'(wr_inc_l), 16'h0);

        // Back-to-back, both byte orders
        next_cycle(); alu_out = 16'h1234; out_valid = 1'b1; settle();
        next_cycle(); out_valid = 1'b0; settle();
        check("b2b_c1_inc", 16'(wr_inc_l), 16'h1);
        check("b2b_c1_lsb", 16'(wr_data_l), 16'h34);
        check("b2b_c1_msb", 16'(wr_data_m), 16'h12);
        next_cycle(); alu_out = 16'hBEEF; out_valid = 1'b1; settle();
        check("b2b_c2_inc", 16'(wr_inc_l), 16'h1);
        check("b2b_c2_lsb", 16'(wr_data_l), 16'h12);
        check("b2b_c2_msb", 16'(wr_data_m), 16'h34);
        check("b2b_c2_ready", 16'(ready_l), 16'h1);
        next_cycle(); out_valid = 1'b0; settle();
        check("b2b_c3_inc", 16'(wr_inc_l), 16'h1);
        check("b2b_c3_lsb", 16'(wr_data_l), 16'hEF);
        check("b2b_c3_msb", 16'(wr_data_m), 16'hBE);
        next_cycle(); settle();
        check("b2b_c4_inc", 16'(wr_inc_l), 16'h1);
        check("b2b_c4_lsb", 16'(wr_data_l), 16'hBE);
        check("b2b_c4_msb", 16'(wr_data_m), 16'hEF);
        next_cycle(); settle();
        check("b2b_c5_inc", 16'(wr_inc_l), 16'h0);
        check("b2b_overrun", 16'(ovr_l), 16'h0);

        // Overrun
        next_cycle(); alu_out = 16'h1111; out_valid = 1'b1; settle();
        next_cycle(); alu_out = 16'h2222; settle();
        check("ov_c1_ready", 16'(ready_l), 16'h0);
        check("ov_c1_data", 16'(wr_data_l), 16'h11);
        check("ov_c1_flag", 16'(ovr_l), 16'h0);
        next_cycle(); out_valid = 1'b0; settle();
        check("ov_c2_flag", 16'(ovr_l), 16'h1);
        check("ov_c2_inc", 16'(wr_inc_l), 16'h1);
        check("ov_c2_data", 16'(wr_data_l), 16'h11);
        next_cycle(); settle();
        check("ov_c3_no_write", 16'(wr_inc_l), 16'h0);
        check("ov_c3_flag", 16'(ovr_l), 16'h1);
        next_cycle(); settle();
        check("ov_c4_flag", 16'(ovr_l), 16'h1);
        next_cycle(); overrun_clr = 1'b1; settle();
        check("ov_c5_flag", 16'(ovr_l), 16'h1);
        next_cycle(); overrun_clr = 1'b0; settle();
        check("ov_c6_cleared", 16'(ovr_l), 16'h0);

        // Set and clear in the same cycle: set wins
        next_cycle(); alu_out = 16'h3333; out_valid = 1'b1; settle();
        next_cycle(); alu_out = 16'h4444; overrun_clr = 1'b1; settle();
        next_cycle(); out_valid = 1'b0; overrun_clr = 1'b0; settle();
        check("ovsc_set_wins", 16'(ovr_l), 16'h1);
        check("ovsc_data", 16'(wr_data_l), 16'h33);
        next_cycle(); overrun_clr = 1'b1; settle();
        check("ovsc_no_write", 16'(wr_inc_l), 16'h0);
        next_cycle(); overrun_clr = 1'b0; settle();
        check("ovsc_cleared", 16'(ovr_l), 16'h0);

        // MSB first
        next_cycle(); alu_out = 16'hC0DE; out_valid = 1'b1; settle();
        next_cycle(); out_valid = 1'b0; settle();
        check("msb_c1_inc", 16'(wr_inc_m), 16'h1);
        check("msb_c1_data", 16'(wr_data_m), 16'hC0);
        check("msb_c1_lsbinst", 16'(wr_data_l), 16'hDE);
        next_cycle(); settle();
        check("msb_c2_data", 16'(wr_data_m), 16'hDE);
        check("msb_c2_ready", 16'(ready_m), 16'h1);
        next_cycle(); settle();
        check("msb_c3_inc", 16'(wr_inc_m), 16'h0);

        // Reset mid-transfer
        next_cycle(); alu_out = 16'h5678; out_valid = 1'b1; settle();
        next_cycle(); out_valid = 1'b0; settle();
        check("mrst_before_inc", 16'(wr_inc_l), 16'h1);
        async_rst = 1'b0;
        #1;
        check("mrst_inc_drop", 16'(wr_inc_l), 16'h0);
        check("mrst_ready", 16'(ready_l), 16'h1);
        check("mrst_data", 16'(wr_data_l), 16'h00);
        #2;
        async_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            next_cycle(); settle();
            check("mrst_no_write", 16'(wr_inc_l), 16'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_tx_ctrl.md
Name: alu_result_tx_ctrl

Overview:
- Consumer end of the ALU result interface.
- Captures each valid ALU result word (e.g. a comparator result) and splits it into bytes.
- Pushes the bytes one by one into the UART TX FIFO write port, honouring FIFO back-pressure.
- Sits between the ALU output register and the TX FIFO, in the same clock domain as the ALU.

Parameters:
DATA_WIDTH, 16, width of the ALU result word; must be an integer multiple of BYTE_WIDTH
BYTE_WIDTH, 8, width of one FIFO entry
LSB_FIRST, 1, 1 = least-significant byte sent first; 0 = most-significant byte first

Ports:
clk  input  1  system clock, all state on rising edge
async_rst  input  1  asynchronous active-low reset
ALU_OUT  input  DATA_WIDTH  ALU result word, valid when OUT_Valid=1
OUT_Valid  input  1  one-cycle strobe; ALU_OUT is aligned with it
FIFO_Full  input  1  TX FIFO full; no write may be issued while high
WR_DATA  output  BYTE_WIDTH  byte presented to the FIFO
WR_INC  output  1  FIFO write strobe, one byte per high cycle
RES_Ready  output  1  block can accept a result this cycle
Overrun  output  1  sticky flag: a result was dropped
Overrun_Clr  input  1  synchronous clear of Overrun

Behaviour:
- Derived constant NUM_BYTES = DATA_WIDTH/BYTE_WIDTH; byte counter width = clog2(NUM_BYTES), minimum 1.
- Reset (async_rst=0, asynchronous):
  - state=IDLE; hold register=0; byte counter=0; Overrun=0.
  - Outputs: WR_INC=0, WR_DATA=0, RES_Ready=1.
- States: IDLE, SEND.
- IDLE:
  - RES_Ready=1, WR_INC=0.
  - On OUT_Valid=1: latch ALU_OUT into hold register, counter=0, go to SEND at the next edge.
- SEND:
  - WR_DATA is combinational from the hold register:
    - LSB_FIRST=1: bits [BYTE_WIDTH-1:0].
    - LSB_FIRST=0: bits [DATA_WIDTH-1:DATA_WIDTH-BYTE_WIDTH].
  - WR_INC = ~FIFO_Full (combinational).
  - On a write cycle (WR_INC=1):
    - Hold register shifts by BYTE_WIDTH toward the sent end, zero-filled.
    - Counter increments.
  - FIFO_Full=1: no write; register and counter hold; WR_DATA stable.
  - Last write (counter=NUM_BYTES-1 and WR_INC=1):
    - With OUT_Valid=1: latch the new ALU_OUT, counter=0, stay in SEND (back-to-back, no bubble).
    - Otherwise: go to IDLE.
- RES_Ready = (state==IDLE) | (state==SEND & counter==NUM_BYTES-1 & ~FIFO_Full).
- Latency:
  - First WR_INC occurs one cycle after the OUT_Valid cycle, provided FIFO_Full=0.
  - With no back-pressure, a word is sent in NUM_BYTES consecutive cycles.
- Dropped results:
  - OUT_Valid=1 while RES_Ready=0: the word is discarded and Overrun is set at the next edge.
  - The in-flight word is unaffected.
- Overrun is cleared by Overrun_Clr=1. If a set and a clear happen in the same cycle, set wins.
- Reset mid-transfer: the remaining bytes are discarded and WR_INC drops immediately (asynchronous).
- WR_INC is never high while FIFO_Full=1; no byte is ever written twice or skipped.
- NUM_BYTES=1: every write cycle is the last write.

Test Plan:
- Reset, idle:
  - Stimulus: assert async_rst=0 mid-cycle, then release.
  - Required: WR_INC=0, RES_Ready=1 and Overrun=0 immediately; no writes afterwards with OUT_Valid=0.
- Single word, LSB_FIRST=1, FIFO_Full=0:
  - Stimulus: ALU_OUT=16'hA55A with OUT_Valid=1 at cycle 0.
  - Required: WR_INC=1 at cycles 1–2; WR_DATA = 8'h5A then 8'hA5; RES_Ready=0 at cycle 1 and 1 at cycle 2; IDLE at cycle 3.
- Back-pressure:
  - Stimulus: ALU_OUT=16'h0001; FIFO_Full=1 for cycles 1–3, then 0.
  - Required: WR_INC=0 with WR_DATA=8'h01 held through cycle 3; writes of 8'h01 at cycle 4 and 8'h00 at cycle 5.
- Back-to-back:
  - Stimulus: 16'h1234 at cycle 0, then 16'hBEEF with OUT_Valid=1 at cycle 2.
  - Required: bytes 34, 12, EF, BE on cycles 1–4 with no gap; Overrun=0.
- Overrun:
  - Stimulus: 16'h1111 at cycle 0, then OUT_Valid=1 with 16'h2222 at cycle 1.
  - Required: only 11, 11 are written; Overrun=1 from cycle 2; Overrun_Clr=1 at cycle 5 gives Overrun=0 at cycle 6.
- MSB first:
  - Stimulus: LSB_FIRST=0, ALU_OUT=16'hC0DE.
  - Required: WR_DATA = 8'hC0 then 8'hDE.
